// File: rtl/conv_enc_if.sv
// conv_enc_if: bit-in / symbol-out handshake bundle for the convolutional encoder
interface conv_enc_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] enc_pair;
  logic       out_valid;
  logic       out_ready;
  modport master (output in_bit, in_valid, out_ready, input in_ready, enc_pair, out_valid);
  modport slave  (input in_bit, in_valid, out_ready, output in_ready, enc_pair, out_valid);
endinterface

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 convolutional encoder with zero-tail termination.
// Optional CONV_ENC_FRAME_CNT_EN adds an 8-bit wrapping frame_cnt output.
module conv_encoder #(
  parameter int           K         = 3,
  parameter logic [K-1:0] G0        = 3'b111,
  parameter logic [K-1:0] G1        = 3'b101,
  parameter int           FRAME_LEN = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  conv_enc_if.slave       bus,
  output logic            busy,
  output logic            frame_done
`ifdef CONV_ENC_FRAME_CNT_EN
  , output logic [7:0]    frame_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ENCODE, FLUSH, DRAIN} state_t;
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [K-2:0] sr, sr_n;
  logic [K-1:0] w, sh;
  logic [1:0]  sym, enc_pair;
  logic        b, load, slot_free, out_valid, in_ready;
  assign slot_free = !out_valid || bus.out_ready;
  assign sh = {sr, b};
  assign sym = {^(w & G0), ^(w & G1)};
  assign busy = state != IDLE;
  assign bus.enc_pair = enc_pair;
  assign bus.out_valid = out_valid;
  assign bus.in_ready = in_ready;
  // codeword orders past bits newest-first below the current bit
  always_comb begin
    w[K-1] = b;
    for (int i = 0; i < K-1; i++) w[K-2-i] = sr[i];
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    load = 1'b0;
    b = 1'b0;
    in_ready = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_n = ENCODE;
        cnt_n = '0;
        sr_n = '0;
      end
      ENCODE: begin
        in_ready = slot_free;
        b = bus.in_bit;
        load = bus.in_valid && slot_free;
        if (load) begin
          cnt_n = cnt + 16'd1;
          if (cnt_n == 16'(FRAME_LEN)) begin
            state_n = FLUSH;
            cnt_n = '0;
          end
        end
      end
      FLUSH: begin
        load = slot_free;
        if (load) begin
          cnt_n = cnt + 16'd1;
          state_n = cnt_n == 16'(K-1) ? DRAIN : FLUSH;
        end
      end
      DRAIN: begin
        frame_done = out_valid && bus.out_ready;
        state_n = frame_done ? IDLE : DRAIN;
      end
      default: state_n = IDLE;
    endcase
    if (load) sr_n = sh[K-2:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      out_valid <= 1'b0;
      enc_pair <= 2'b00;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      if (load) begin
        out_valid <= 1'b1;
        enc_pair <= sym;
      end else if (bus.out_ready) out_valid <= 1'b0;
    end
  end
`ifdef CONV_ENC_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: table-driven directed frames plus reset/idle/random sequences.
module tb_conv_encoder;
  logic clk, rst, start, busy, frame_done;
`ifdef CONV_ENC_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif
  conv_enc_if bus();
  conv_encoder #(.FRAME_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .frame_done(frame_done)
`ifdef CONV_ENC_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );
  typedef struct {
    logic [3:0]  bits;
    logic        stall;
    logic        mid_start;
    logic [11:0] exp;
  } vec_t;
  vec_t vt[6];
  int total = 0, bad = 0;
  logic stall_mode = 1'b0;
  logic [2:0] got[$];
  logic pv_stall = 1'b0;
  logic [1:0] penc;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    int cyc = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.out_ready = stall_mode ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (rst) pv_stall = 1'b0;
    else begin
      if (pv_stall) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_pair", int'(bus.enc_pair), int'(penc));
      end
      if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", int'(bus.in_ready), 0);
      if (bus.out_valid && bus.out_ready) got.push_back({frame_done, bus.enc_pair});
      else if (frame_done) chk("stray_done", int'(frame_done), 0);
      pv_stall = bus.out_valid && !bus.out_ready;
      penc = bus.enc_pair;
    end
  end
  task automatic run_frame(input logic [3:0] bits, input logic stall, input logic mid_start);
    logic ok;
    stall_mode = stall;
    got.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = mid_start;
    for (int i = 3; i >= 0; i--) begin
      bus.in_valid = 1'b1;
      bus.in_bit = bits[i];
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk);
        #1;
      end
      chk("in_accept", int'(ok), 1);
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = !busy;
    end
    chk("frame_end", int'(ok), 1);
    stall_mode = 1'b0;
  endtask
  task automatic check_frame(input logic [11:0] exp);
    chk("sym_count", got.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) begin
        chk($sformatf("sym%0d", i), int'(got[i][1:0]), int'(exp[11-2*i -: 2]));
        chk($sformatf("done%0d", i), int'(got[i][2]), int'(i == 5));
      end
  endtask
  function automatic logic [11:0] enc_model(input logic [3:0] bits);
    logic [11:0] r = '0;
    logic p1 = 1'b0, p2 = 1'b0, x;
    for (int i = 0; i < 6; i++) begin
      x = i < 4 ? bits[3-i] : 1'b0;
      r = {r[9:0], x ^ p1 ^ p2, x ^ p2};
      p2 = p1;
      p1 = x;
    end
    return r;
  endfunction
  initial begin
    logic [3:0] rb;
    logic [11:0] re;
    logic d, s0, s1;
    vt[0] = '{4'b1011, 1'b0, 1'b0, 12'b11_10_00_01_01_11};
    vt[1] = '{4'b1011, 1'b1, 1'b0, 12'b11_10_00_01_01_11};
    vt[2] = '{4'b0110, 1'b0, 1'b1, 12'b00_11_01_01_11_00};
    vt[3] = '{4'b1000, 1'b1, 1'b0, 12'b11_10_11_00_00_00};
    vt[4] = '{4'b0000, 1'b0, 1'b0, 12'b00_00_00_00_00_00};
    vt[5] = '{4'b0000, 1'b0, 1'b0, 12'b00_00_00_00_00_00};
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_enc_pair", int'(bus.enc_pair), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
`ifdef CONV_ENC_FRAME_CNT_EN
    chk("rst_frame_cnt", int'(frame_cnt), 0);
`endif
    rst = 1'b0;
    for (int v = 0; v < 6; v++) begin
      run_frame(vt[v].bits, vt[v].stall, vt[v].mid_start);
      check_frame(vt[v].exp);
    end
`ifdef CONV_ENC_FRAME_CNT_EN
    chk("frame_cnt", int'(frame_cnt), 6);
`endif
    got.delete();
    bus.in_valid = 1'b1;
    bus.in_bit = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_in_ready", int'(bus.in_ready), 0);
      chk("idle_busy", int'(busy), 0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("idle_no_syms", got.size(), 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit = i[0] ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(bus.in_ready), 0);
    run_frame(4'b1111, 1'b0, 1'b0);
    check_frame(12'b11_01_10_10_01_11);
    for (int r = 0; r < 4; r++) begin
      rb = 4'($urandom);
      re = enc_model(rb);
      run_frame(rb, r[0], 1'b0);
      check_frame(re);
      s0 = 1'b0;
      s1 = 1'b0;
      for (int i = 0; i < 4; i++)
        if (i < got.size()) begin
          d = got[i][1] ^ s0 ^ s1;
          chk($sformatf("decode%0d", i), int'(d), int'(rb[3-i]));
          s1 = s0;
          s0 = d;
        end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
